// File: rtl/puf_vote_sequencer.sv
// puf_vote_sequencer: fetches challenges, majority-votes VOTES PUF evaluations per word,
// writes each voted word back and counts non-unanimous bits.
module puf_vote_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int VOTES      = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [3:0]            num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [15:0]           unstable_cnt,
  output logic [ADDR_WIDTH-1:0] chal_rd_addr,
  input  logic [DATA_WIDTH-1:0] chal_rd_data,
  output logic                  puf_req,
  output logic [DATA_WIDTH-1:0] puf_challenge,
  input  logic                  puf_ack,
  input  logic [DATA_WIDTH-1:0] puf_resp,
  output logic                  res_wr_en,
  output logic [ADDR_WIDTH-1:0] res_wr_addr,
  output logic [DATA_WIDTH-1:0] res_wr_data
);
  localparam int CW = $clog2(VOTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int UW = $clog2(DATA_WIDTH + 1);
  localparam logic [3:0] MAXN = 4'(NUM_WORDS);
  typedef enum logic [2:0] {IDLE, RD, RDW, REQ, ACC, WR, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_w;
  logic [3:0] r_n;
  logic [CW-1:0] r_v;
  logic [TW-1:0] r_to;
  logic [DATA_WIDTH-1:0] r_resp, w_vote;
  logic [CW-1:0] r_cnt [DATA_WIDTH];
  logic [CW-1:0] w_cnt [DATA_WIDTH];
  logic [UW-1:0] w_unst;
  logic [16:0] w_sum;
  logic w_last_vote, w_last_word, w_tmo;
  assign chal_rd_addr = r_w;
  assign res_wr_addr  = r_w;
  assign w_last_vote  = r_v == CW'(VOTES - 1);
  assign w_last_word  = 4'(r_w) + 4'd1 == r_n;
  assign w_tmo        = r_to == TW'(TIMEOUT - 1);
  assign w_sum        = {1'b0, unstable_cnt} + 17'(w_unst);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (num_words == 4'd0 ? DONE : RD) : IDLE;
      RD:      w_next = RDW;
      RDW:     w_next = REQ;
      REQ:     w_next = puf_ack ? ACC : (w_tmo ? DONE : REQ);
      ACC:     w_next = w_last_vote ? WR : REQ;
      WR:      w_next = w_last_word ? DONE : RD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // counts include the response captured in the preceding REQ cycle
  always_comb begin
    w_cnt  = '{default: '0};
    w_vote = '0;
    w_unst = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_cnt[i]  = r_cnt[i] + CW'(r_resp[i]);
      w_vote[i] = w_cnt[i] > CW'(VOTES / 2);
      w_unst    = w_unst + UW'(w_cnt[i] != '0 && w_cnt[i] != CW'(VOTES));
    end
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_state       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      unstable_cnt  <= '0;
      puf_req       <= 1'b0;
      puf_challenge <= '0;
      res_wr_en     <= 1'b0;
      res_wr_data   <= '0;
      r_w           <= '0;
      r_n           <= '0;
      r_v           <= '0;
      r_to          <= '0;
      r_resp        <= '0;
      r_cnt         <= '{default: '0};
    end else begin
      r_state   <= w_next;
      busy      <= w_next != IDLE;
      done      <= w_next == DONE;
      puf_req   <= w_next == REQ;
      res_wr_en <= w_next == WR;
      case (r_state)
        IDLE: if (start) begin
          r_n          <= num_words > MAXN ? MAXN : num_words;
          r_w          <= '0;
          err_timeout  <= 1'b0;
          unstable_cnt <= '0;
        end
        RDW: begin
          puf_challenge <= chal_rd_data;
          r_cnt         <= '{default: '0};
          r_v           <= '0;
          r_to          <= '0;
        end
        REQ: begin
          r_to <= r_to + 1'b1;
          if (puf_ack) r_resp <= puf_resp;
          else if (w_tmo) err_timeout <= 1'b1;
        end
        ACC: begin
          r_cnt <= w_cnt;
          r_v   <= r_v + 1'b1;
          r_to  <= '0;
          if (w_last_vote) begin
            res_wr_data  <= w_vote;
            unstable_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
          end
        end
        WR: if (!w_last_word) r_w <= r_w + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_puf_vote_sequencer.sv
// tb_puf_vote_sequencer: directed runs against a buffer/PUF model; writes checked via a scoreboard queue.
module tb_puf_vote_sequencer;
  logic ACLK = 1'b0, ARESET, start;
  logic [3:0] num_words;
  logic busy, done, err_timeout, puf_req, puf_ack, res_wr_en;
  logic [15:0] unstable_cnt;
  logic [2:0] chal_rd_addr, res_wr_addr;
  logic [31:0] chal_rd_data, puf_challenge, puf_resp, res_wr_data;
  logic [31:0] mem [8];
  logic [34:0] exp_q [$];
  logic [34:0] e;
  logic mode, blk;
  int ack_cnt, req_cnt, req2_cnt, wr_cnt, n_cmp, n_bad, lat, w0;

  puf_vote_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .num_words(num_words),
    .busy(busy), .done(done), .err_timeout(err_timeout), .unstable_cnt(unstable_cnt),
    .chal_rd_addr(chal_rd_addr), .chal_rd_data(chal_rd_data),
    .puf_req(puf_req), .puf_challenge(puf_challenge), .puf_ack(puf_ack), .puf_resp(puf_resp),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) chal_rd_data <= mem[chal_rd_addr];

  // mode 1 answers F,0,F,0,F for every word; blk withholds ack for challenge 2
  always_comb begin
    puf_ack  = puf_req && !(blk && puf_challenge == 32'd2);
    puf_resp = mode ? (((ack_cnt % 5) % 2 == 0) ? 32'hFFFF_FFFF : 32'h0) : puf_challenge ^ 32'hA5A5_A5A5;
  end

  always @(posedge ACLK) begin
    ack_cnt  <= start ? 0 : (puf_req && puf_ack ? ack_cnt + 1 : ack_cnt);
    req_cnt  <= start ? 0 : (puf_req ? req_cnt + 1 : req_cnt);
    req2_cnt <= start ? 0 : (puf_req && puf_challenge == 32'd2 ? req2_cnt + 1 : req2_cnt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge ACLK) if (!ARESET && res_wr_en) begin
    wr_cnt++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write: addr %0d data %h, no write required", res_wr_addr, res_wr_data);
    end else begin
      e = exp_q.pop_front();
      chk("wr_addr", 32'(res_wr_addr), 32'(e[34:32]));
      chk("wr_data", res_wr_data, e[31:0]);
    end
  end

  task automatic pulse_start(input logic [3:0] n);
    @(posedge ACLK); #1;
    start = 1'b1;
    num_words = n;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int l);
    l = 0;
    do begin
      @(negedge ACLK);
      l++;
    end while (!done && l < bound);
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
  endtask

  task automatic push_words(input int n, input logic m);
    for (int k = 0; k < n; k++)
      exp_q.push_back({3'(k), m ? 32'hFFFF_FFFF : (32'(k + 1) ^ 32'hA5A5_A5A5)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; wr_cnt = 0;
    for (int k = 0; k < 8; k++) mem[k] = 32'(k + 1);
    ARESET = 1'b1; start = 1'b0; num_words = 4'd0; mode = 1'b0; blk = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_unstable", 32'(unstable_cnt), 0);
    chk("rst_req", 32'(puf_req), 0);
    chk("rst_wr_en", 32'(res_wr_en), 0);
    chk("rst_wr_data", res_wr_data, 0);
    chk("rst_chal", puf_challenge, 0);

    // eight words, zero-wait ack
    push_words(8, 1'b0);
    pulse_start(4'd8);
    wait_done(400, lat);
    chk("n8_latency", 32'(lat), 105);
    chk("n8_unstable", 32'(unstable_cnt), 0);
    chk("n8_err", 32'(err_timeout), 0);
    chk("n8_pending", 32'(exp_q.size()), 0);
    @(negedge ACLK);
    chk("n8_busy_after", 32'(busy), 0);
    chk("n8_done_pulse", 32'(done), 0);

    // split responses: 3 of 5 ones on every bit
    mode = 1'b1;
    push_words(1, 1'b1);
    pulse_start(4'd1);
    wait_done(100, lat);
    chk("vote_latency", 32'(lat), 14);
    chk("vote_unstable", 32'(unstable_cnt), 32);
    chk("vote_pending", 32'(exp_q.size()), 0);
    mode = 1'b0;

    // second word never acked
    blk = 1'b1;
    push_words(1, 1'b0);
    pulse_start(4'd3);
    wait_done(1000, lat);
    chk("tmo_latency", 32'(lat), 271);
    chk("tmo_err", 32'(err_timeout), 1);
    chk("tmo_req_cycles", 32'(req2_cnt), 255);
    chk("tmo_pending", 32'(exp_q.size()), 0);
    blk = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("tmo_req_dropped", 32'(puf_req), 0);

    // zero words
    w0 = wr_cnt;
    pulse_start(4'd0);
    wait_done(10, lat);
    chk("n0_latency", 32'(lat), 1);
    chk("n0_req", 32'(req_cnt), 0);
    chk("n0_writes", 32'(wr_cnt - w0), 0);
    chk("n0_err_cleared", 32'(err_timeout), 0);

    // count clamp
    w0 = wr_cnt;
    push_words(8, 1'b0);
    pulse_start(4'd12);
    wait_done(400, lat);
    chk("n12_latency", 32'(lat), 105);
    chk("n12_writes", 32'(wr_cnt - w0), 8);
    chk("n12_pending", 32'(exp_q.size()), 0);

    // start while busy is ignored
    w0 = wr_cnt;
    push_words(3, 1'b0);
    pulse_start(4'd3);
    repeat (5) @(posedge ACLK);
    #1 start = 1'b1; num_words = 4'd8;
    @(posedge ACLK);
    #1 start = 1'b0;
    wait_done(200, lat);
    chk("restart_latency", 32'(lat), 34);
    chk("restart_writes", 32'(wr_cnt - w0), 3);
    chk("restart_pending", 32'(exp_q.size()), 0);

    // asynchronous reset during word 4
    mode = 1'b1;
    push_words(4, 1'b1);
    pulse_start(4'd8);
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
    end while (!(puf_req && puf_challenge == 32'd5) && lat < 200);
    chk("mid_reached_word4", 32'(puf_req && puf_challenge == 32'd5), 1);
    chk("mid_unstable", 32'(unstable_cnt), 128);
    #1 ARESET = 1'b1;
    #1;
    chk("mid_rst_req", 32'(puf_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr_en", 32'(res_wr_en), 0);
    chk("mid_rst_unstable", 32'(unstable_cnt), 0);
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("mid_pending", 32'(exp_q.size()), 0);
    chk("mid_no_done", 32'(done), 0);
    push_words(1, 1'b1);
    pulse_start(4'd1);
    wait_done(100, lat);
    chk("fresh_latency", 32'(lat), 14);
    chk("fresh_unstable", 32'(unstable_cnt), 32);
    chk("fresh_pending", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
